// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizing for the register-file write-back controller.
package regfile_ctrl_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ADDR_W     = $clog2(NUM_REGS);
    localparam int unsigned DATA_W     = 32;
    // Consecutive ALU losses tolerated before the ALU is force-granted.
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GntNone,
        GntAlu,
        GntLsu
    } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus the issue hazard compare.
module rf_scoreboard
    import regfile_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iss_valid_i,
    input  logic                iss_wb_i,
    input  reg_addr_t           iss_rd_i,
    input  reg_addr_t           iss_rs1_i,
    input  reg_addr_t           iss_rs2_i,
    output logic                iss_stall_o,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                set_en;

    // Hazard detect and reservation of the destination on a successful issue.
    always_comb begin
        iss_stall_o = iss_valid_i &
                      (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | (iss_wb_i & busy_q[iss_rd_i]));
        set_en      = iss_valid_i & ~iss_stall_o & iss_wb_i & (iss_rd_i != '0);
    end

    // Next busy vector: clear first so a same-cycle reservation of that register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU onto the single regfile write port,
// registers the write, and tracks pending destinations to stall hazardous issue.
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iss_valid_i,
    input  logic                iss_wb_i,
    input  logic [ADDR_W-1:0]   iss_rd_i,
    input  logic [ADDR_W-1:0]   iss_rs1_i,
    input  logic [ADDR_W-1:0]   iss_rs2_i,
    output logic                iss_stall_o,
    input  logic                alu_valid_i,
    input  logic [ADDR_W-1:0]   alu_rd_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    output logic                alu_ready_o,
    input  logic                lsu_valid_i,
    input  logic [ADDR_W-1:0]   lsu_rd_i,
    input  logic [DATA_W-1:0]   lsu_data_i,
    output logic                lsu_ready_o,
    output logic                reg_wr_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam logic [STARVE_W-1:0] StarveLimit = STARVE_W'(STARVE_MAX);

    gnt_e                gnt;
    wb_req_t             alu_req, lsu_req, sel_req;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_en_q, wr_en_d;
    wb_req_t             out_q, out_d;

    assign alu_req = '{rd: alu_rd_i, data: alu_data_i};
    assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

    // Arbiter: LSU has priority except when the ALU has lost StarveLimit times in a row.
    always_comb begin
        gnt = GntNone;
        if (alu_valid_i && (!lsu_valid_i || starve_q == StarveLimit)) begin
            gnt = GntAlu;
        end else if (lsu_valid_i) begin
            gnt = GntLsu;
        end
    end

    assign alu_ready_o = (gnt == GntAlu);
    assign lsu_ready_o = (gnt == GntLsu);

    // Starvation counter and write-port register next state.
    always_comb begin
        starve_d = starve_q;
        wr_en_d  = 1'b0;
        out_d    = out_q;
        sel_req  = '0;
        unique case (gnt)
            GntAlu: begin
                sel_req  = alu_req;
                starve_d = '0;
            end
            GntLsu: begin
                sel_req = lsu_req;
                if (alu_valid_i && starve_q != StarveLimit) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            default: ;
        endcase
        // x0 writes are accepted but never reach the regfile.
        if (gnt != GntNone && sel_req.rd != '0) begin
            wr_en_d = 1'b1;
            out_d   = sel_req;
        end
    end

    // State registers with synchronous reset; a grant in flight is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
            wr_en_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            out_q    <= out_d;
        end
    end

    assign reg_wr_en_o = wr_en_q;
    assign rd_addr_o   = out_q.rd;
    assign wr_data_o   = out_q.data;

    // The registered write clears the busy bit, so it is low two cycles after the grant.
    rf_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iss_valid_i (iss_valid_i),
        .iss_wb_i    (iss_wb_i),
        .iss_rd_i    (iss_rd_i),
        .iss_rs1_i   (iss_rs1_i),
        .iss_rs2_i   (iss_rs2_i),
        .iss_stall_o (iss_stall_o),
        .clr_en_i    (wr_en_q),
        .clr_addr_i  (out_q.rd),
        .busy_o      (busy_o)
    );

    // Protocol check: a write-back must target a register that issue reserved.
    always_ff @(posedge clk_i) begin
        if (!rst_i && gnt != GntNone && sel_req.rd != '0) begin
            assert (busy_o[sel_req.rd])
            else $error("regfile_wb_ctrl: write-back to non-busy register x%0d", sel_req.rd);
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios plus randomized traffic.
module tb_regfile_wb_ctrl;

    localparam int NREGS = 32;
    localparam int SMAX  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_wb, iss_stall;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rd_addr;
    logic [31:0] alu_data, lsu_data, wr_data;
    logic        reg_wr_en;
    logic [31:0] busy;

    regfile_wb_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .iss_valid_i (iss_valid),
        .iss_wb_i    (iss_wb),
        .iss_rd_i    (iss_rd),
        .iss_rs1_i   (iss_rs1),
        .iss_rs2_i   (iss_rs2),
        .iss_stall_o (iss_stall),
        .alu_valid_i (alu_valid),
        .alu_rd_i    (alu_rd),
        .alu_data_i  (alu_data),
        .alu_ready_o (alu_ready),
        .lsu_valid_i (lsu_valid),
        .lsu_rd_i    (lsu_rd),
        .lsu_data_i  (lsu_data),
        .lsu_ready_o (lsu_ready),
        .reg_wr_en_o (reg_wr_en),
        .rd_addr_o   (rd_addr),
        .wr_data_o   (wr_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    checks = 0;
    wr_t   exp_q[$];
    bit    busy_m[NREGS];
    int    starve_m = 0;
    bit    clr_pend = 0;
    logic [4:0] clr_addr;
    bit    mon_en = 0;
    bit    auto_rq = 0;
    int    alu_pend[$];
    int    lsu_pend[$];
    bit    alu_hold = 0, lsu_hold = 0;
    string dut_gnt;

    // Decisions of the cycle in flight, applied to the model at the clock edge.
    bit         s_rst, s_set, s_galu, s_glsu, s_alu_v;
    logic [4:0] s_rd, s_alu_rd, s_lsu_rd;
    logic [31:0] s_alu_data, s_lsu_data;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = busy_m[i];
        return v;
    endfunction

    // Model update at the clock edge, straight from the behavioural rules.
    task automatic commit();
        if (s_rst) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            starve_m = 0;
            clr_pend = 1'b0;
            exp_q.delete();
            alu_pend.delete();
            lsu_pend.delete();
            alu_hold = 1'b0;
            lsu_hold = 1'b0;
            return;
        end
        if (clr_pend) busy_m[clr_addr] = 1'b0;
        clr_pend = 1'b0;
        if (s_set) begin
            busy_m[s_rd] = 1'b1;
            if (auto_rq) begin
                if ($urandom_range(0, 1) == 0) alu_pend.push_back(int'(s_rd));
                else lsu_pend.push_back(int'(s_rd));
            end
        end
        if (s_galu) begin
            starve_m = 0;
            alu_hold = 1'b0;
            if (s_alu_rd != 0) begin
                exp_q.push_back('{rd: s_alu_rd, data: s_alu_data});
                clr_pend = 1'b1;
                clr_addr = s_alu_rd;
            end
        end else if (s_alu_v) begin
            starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
        end
        if (s_glsu) begin
            lsu_hold = 1'b0;
            if (s_lsu_rd != 0) begin
                exp_q.push_back('{rd: s_lsu_rd, data: s_lsu_data});
                clr_pend = 1'b1;
                clr_addr = s_lsu_rd;
            end
        end
    endtask

    // One clock: check combinational outputs, advance, update model. Ends at edge+2.
    task automatic tick();
        bit g_alu, g_lsu, e_stall;
        #1;
        g_alu   = alu_valid && (!lsu_valid || starve_m == SMAX);
        g_lsu   = lsu_valid && !g_alu;
        e_stall = iss_valid && (busy_m[iss_rs1] || busy_m[iss_rs2] || (iss_wb && busy_m[iss_rd]));
        check("alu_ready", alu_ready, g_alu);
        check("lsu_ready", lsu_ready, g_lsu);
        check("iss_stall", iss_stall, e_stall);
        if (alu_ready) dut_gnt = {dut_gnt, "A"};
        if (lsu_ready) dut_gnt = {dut_gnt, "L"};
        s_rst      = rst;
        s_set      = iss_valid && !e_stall && iss_wb && iss_rd != 0;
        s_rd       = iss_rd;
        s_galu     = g_alu;
        s_glsu     = g_lsu;
        s_alu_v    = alu_valid;
        s_alu_rd   = alu_rd;
        s_alu_data = alu_data;
        s_lsu_rd   = lsu_rd;
        s_lsu_data = lsu_data;
        @(posedge clk);
        vectors++;
        #1;
        commit();
        #1;
    endtask

    task automatic set_idle();
        iss_valid = 0; iss_wb = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic drive_random(bit issue_on);
        iss_valid = issue_on && ($urandom_range(0, 99) < 60);
        iss_wb    = ($urandom_range(0, 3) != 0);
        iss_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        iss_rs1   = 5'($urandom_range(0, 31));
        iss_rs2   = 5'($urandom_range(0, 31));
        if (!alu_hold) begin
            if (alu_pend.size() != 0 && $urandom_range(0, 99) < 60) begin
                alu_rd = 5'(alu_pend.pop_front()); alu_data = $urandom; alu_hold = 1;
            end else if ($urandom_range(0, 99) < 4) begin
                alu_rd = 5'd0; alu_data = $urandom; alu_hold = 1;
            end
        end
        if (!lsu_hold) begin
            if (lsu_pend.size() != 0 && $urandom_range(0, 99) < 70) begin
                lsu_rd = 5'(lsu_pend.pop_front()); lsu_data = $urandom; lsu_hold = 1;
            end else if ($urandom_range(0, 99) < 4) begin
                lsu_rd = 5'd0; lsu_data = $urandom; lsu_hold = 1;
            end
        end
        alu_valid = alu_hold;
        lsu_valid = lsu_hold;
    endtask

    // Monitor: registered write port and busy vector against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_en", reg_wr_en, 1);
                check("rd_addr", rd_addr, e.rd);
                check("wr_data", wr_data, e.data);
            end else begin
                check("wr_en_idle", reg_wr_en, 0);
            end
            check("busy", busy, busy_vec());
        end
    end

    initial begin
        int aq[$];
        int lq[$];
        set_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        mon_en = 1;
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_busy", busy, 0);

        // Solo ALU write of x5.
        set_idle(); iss_valid = 1; iss_wb = 1; iss_rd = 5; tick();
        set_idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF; tick();
        check("solo_en", reg_wr_en, 1);
        check("solo_rd", rd_addr, 5);
        check("solo_data", wr_data, 32'hDEAD_BEEF);
        set_idle(); tick();
        check("solo_pulse", reg_wr_en, 0);

        // RAW stall on x7 released two cycles after the grant.
        set_idle(); iss_valid = 1; iss_wb = 1; iss_rd = 7; tick();
        check("raw_busy_set", busy[7], 1);
        set_idle(); iss_valid = 1; iss_rs1 = 7; tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_7777; tick();
        alu_valid = 0; tick();
        check("raw_busy_clr", busy[7], 0);
        tick();

        // x0 issue and write are both no-ops for the scoreboard and the port.
        set_idle(); iss_valid = 1; iss_wb = 1; iss_rd = 0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234_5678; tick();
        set_idle(); tick();
        check("x0_no_write", reg_wr_en, 0);

        // Both requesters saturated: LSU x3 then a forced ALU grant.
        for (int i = 8; i < 16; i++) begin
            set_idle(); iss_valid = 1; iss_wb = 1; iss_rd = 5'(i); tick();
        end
        aq = '{8, 9};
        lq = '{10, 11, 12, 13, 14, 15};
        dut_gnt = "";
        while (aq.size() != 0 || lq.size() != 0) begin
            set_idle();
            alu_valid = (aq.size() != 0);
            if (alu_valid) begin alu_rd = 5'(aq[0]); alu_data = 32'hA000_0000 + aq[0]; end
            lsu_valid = (lq.size() != 0);
            if (lsu_valid) begin lsu_rd = 5'(lq[0]); lsu_data = 32'hB000_0000 + lq[0]; end
            tick();
            if (s_galu) void'(aq.pop_front());
            if (s_glsu) void'(lq.pop_front());
        end
        checks++;
        if (dut_gnt != "LLLALLLA") begin
            miscompares++;
            $display("FAIL grant_order: got %s expected LLLALLLA", dut_gnt);
        end
        set_idle(); tick(); tick();

        // Randomized traffic with a reset dropped into the middle.
        auto_rq = 1;
        for (int i = 0; i < 700; i++) begin
            if (i == 350) begin
                set_idle();
                rst = 1;
                tick();
                tick();
                rst = 0;
                check("mid_rst_en", reg_wr_en, 0);
                check("mid_rst_rd", rd_addr, 0);
                check("mid_rst_data", wr_data, 0);
                check("mid_rst_busy", busy, 0);
            end
            drive_random(i < 640);
            tick();
        end
        set_idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
